// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: captures the winning request and owns the memory port until mem_done.
// Define MEM_ARB_RR_EN for round-robin between simultaneous requests; otherwise A has fixed priority.
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_rden,
  input  logic            a_wren,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_wdata,
  input  logic [DW/8-1:0] a_wmask,
  output logic            a_done,
  input  logic            b_rden,
  input  logic            b_wren,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_wdata,
  input  logic [DW/8-1:0] b_wmask,
  output logic            b_done,
  output logic [DW-1:0]   rdata,
  output logic            mem_rden,
  output logic            mem_wren,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_done,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned MW = DW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            op_wr_q;
  logic            last_grant_q;   // 1 = B was granted last
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [MW-1:0]   wmask_q;

  logic a_req, b_req, pick_a, pick_b;

  assign a_req = a_rden | a_wren;
  assign b_req = b_rden | b_wren;

  // Winner selection for the IDLE cycle
`ifdef MEM_ARB_RR_EN
  assign pick_b = b_req & (~a_req | ~last_grant_q);
`else
  assign pick_b = b_req & ~a_req;
`endif
  assign pick_a = a_req & ~pick_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_a) begin
          state_d = OWN_A;
        end else if (pick_b) begin
          state_d = OWN_B;
        end
      end
      OWN_A, OWN_B: begin
        if (mem_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request payload is frozen at grant; later changes by the owner are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      op_wr_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else if (state_q == IDLE && (a_req || b_req)) begin
      op_wr_q      <= pick_b ? b_wren : a_wren;
      last_grant_q <= pick_b;
      addr_q       <= pick_b ? b_addr : a_addr;
      wdata_q      <= pick_b ? b_wdata : a_wdata;
      wmask_q      <= pick_b ? b_wmask : a_wmask;
    end
  end

  // Done is suppressed under reset so an abandoned transaction never completes
  always_comb begin
    mem_rden  = 1'b0;
    mem_wren  = 1'b0;
    a_done    = 1'b0;
    b_done    = 1'b0;
    rdata     = mem_rdata;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wmask = wmask_q;
    if (state_q == OWN_A || state_q == OWN_B) begin
      mem_rden = ~op_wr_q;
      mem_wren = op_wr_q;
    end
    if (state_q == OWN_A) begin
      a_done = mem_done & ~rst;
    end
    if (state_q == OWN_B) begin
      b_done = mem_done & ~rst;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_rden = 0, a_wren = 0, b_rden = 0, b_wren = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic [3:0]  a_wmask = 0, b_wmask = 0;
  logic        a_done, b_done;
  logic [31:0] rdata;
  logic        mem_rden, mem_wren;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_done = 0;
  logic [31:0] mem_rdata = 0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .a_rden(a_rden), .a_wren(a_wren), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_wmask(a_wmask), .a_done(a_done),
    .b_rden(b_rden), .b_wren(b_wren), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_wmask(b_wmask), .b_done(b_done),
    .rdata(rdata), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: owner 0 = nobody, 1 = A, 2 = B
  int          m_owner = 0;
  int          m_last  = 2;
  bit          m_wr    = 0;
  logic [31:0] m_addr  = 0, m_wdata = 0;
  logic [3:0]  m_wmask = 0;
  int          w;

  function automatic int winner(input bit pa, input bit pb, input int last);
    if (pa && pb) begin
`ifdef MEM_ARB_RR_EN
      return (last == 1) ? 2 : 1;
`else
      return 1;
`endif
    end
    if (pa) return 1;
    if (pb) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0; m_last = 2; m_wr = 0; m_addr = 0; m_wdata = 0; m_wmask = 0;
    end else if (m_owner != 0) begin
      if (mem_done) m_owner = 0;
    end else begin
      w = winner(a_rden | a_wren, b_rden | b_wren, m_last);
      if (w == 1) begin
        m_wr = a_wren; m_addr = a_addr; m_wdata = a_wdata; m_wmask = a_wmask;
      end else if (w == 2) begin
        m_wr = b_wren; m_addr = b_addr; m_wdata = b_wdata; m_wmask = b_wmask;
      end
      if (w != 0) begin
        m_owner = w; m_last = w;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rden",  64'(mem_rden),  64'(m_owner != 0 && !m_wr));
      chk("model_wren",  64'(mem_wren),  64'(m_owner != 0 && m_wr));
      chk("model_adone", 64'(a_done),    64'(m_owner == 1 && mem_done && !rst));
      chk("model_bdone", 64'(b_done),    64'(m_owner == 2 && mem_done && !rst));
      chk("model_addr",  64'(mem_addr),  64'(m_addr));
      chk("model_wdata", 64'(mem_wdata), 64'(m_wdata));
      chk("model_wmask", 64'(mem_wmask), 64'(m_wmask));
      if (a_done || b_done) chk("model_rdata", 64'(rdata), 64'(mem_rdata));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Grant edge, then a one-cycle memory completion; returns in the following IDLE cycle
  task automatic xact(input string nm, input logic [31:0] exp_addr, input bit exp_b);
    cyc();
    mem_done  = 1'b1;
    mem_rdata = exp_addr ^ 32'hA5A5_0000;
    @(negedge clk);
    chk({nm, "_addr"}, 64'(mem_addr), 64'(exp_addr));
    chk({nm, "_owner"}, 64'({a_done, b_done}), exp_b ? 64'd1 : 64'd2);
    cyc();
    mem_done = 1'b0;
  endtask

  initial begin
    cyc();
    chk_en = 1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_strobes", 64'({mem_rden, mem_wren, a_done, b_done}), 64'd0);
    chk("rst_payload", 64'({mem_addr, mem_wmask}), 64'd0);

    // A read at 0x100, completion three cycles into the strobe
    cyc();
    a_rden = 1'b1; a_addr = 32'h100;
    cyc();
    @(negedge clk);
    chk("rd_c1_rden", 64'(mem_rden), 64'd1);
    chk("rd_c1_addr", 64'(mem_addr), 64'h100);
    cyc();
    @(negedge clk);
    chk("rd_c2_rden", 64'({mem_rden, a_done}), 64'b10);
    cyc();
    mem_done = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd_c3_done", 64'({mem_rden, a_done, b_done}), 64'b110);
    chk("rd_c3_rdata", 64'(rdata), 64'hDEAD_BEEF);
    cyc();
    mem_done = 1'b0; a_rden = 1'b0;
    @(negedge clk);
    chk("rd_idle_rden", 64'(mem_rden), 64'd0);

    // Simultaneous requests straight after reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    a_rden = 1'b1; a_addr = 32'h10;
    b_rden = 1'b1; b_addr = 32'h20;
    xact("arb1", 32'h10, 1'b0);
    a_addr = 32'h14;
`ifdef MEM_ARB_RR_EN
    xact("rr2", 32'h20, 1'b1);
    b_rden = 1'b0;
    xact("rr3", 32'h14, 1'b0);
    a_rden = 1'b0;
`else
    xact("fp2", 32'h14, 1'b0);
    a_addr = 32'h18;
    xact("fp3", 32'h18, 1'b0);
    a_rden = 1'b0;
    xact("fp4", 32'h20, 1'b1);
    b_rden = 1'b0;
`endif
    cyc();

    // B write; payload changes after grant must not reach the memory port
    b_wren = 1'b1; b_addr = 32'h40; b_wdata = 32'h1234_5678; b_wmask = 4'h3;
    cyc();
    b_addr = 32'h44; b_wdata = 32'hFFFF_FFFF; b_wmask = 4'hF;
    @(negedge clk);
    chk("wr_c1", 64'({mem_wren, mem_rden}), 64'b10);
    cyc();
    @(negedge clk);
    chk("wr_c2_wdata", 64'(mem_wdata), 64'h1234_5678);
    chk("wr_c2_wmask", 64'(mem_wmask), 64'h3);
    cyc();
    mem_done = 1'b1;
    @(negedge clk);
    chk("wr_c3_done", 64'({b_done, a_done}), 64'b10);
    chk("wr_c3_hold", 64'({mem_addr, mem_wdata}), {32'h40, 32'h1234_5678});
    cyc();
    mem_done = 1'b0; b_wren = 1'b0;

    // Both rden and wren high is a write
    a_rden = 1'b1; a_wren = 1'b1; a_addr = 32'h80; a_wdata = 32'hCAFE_0001; a_wmask = 4'hC;
    cyc();
    @(negedge clk);
    chk("rw_is_write", 64'({mem_wren, mem_rden}), 64'b10);
    cyc();
    mem_done = 1'b1;
    cyc();
    mem_done = 1'b0; a_rden = 1'b0; a_wren = 1'b0;

    // Reset during OWN_A with a coincident mem_done
    a_rden = 1'b1; a_addr = 32'h200;
    cyc();
    rst = 1'b1; mem_done = 1'b1;
    @(negedge clk);
    chk("rstmid_nodone", 64'({a_done, b_done}), 64'd0);
    cyc();
    rst = 1'b0; mem_done = 1'b0; a_rden = 1'b0;
    @(negedge clk);
    chk("rstmid_idle", 64'({mem_rden, mem_wren, a_done}), 64'd0);
    chk("rstmid_addr", 64'(mem_addr), 64'd0);

    // Stray mem_done in IDLE
    cyc();
    mem_done = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("idle_done", 64'({a_done, b_done, mem_rden, mem_wren}), 64'd0);
    cyc();
    mem_done = 1'b0;
    @(negedge clk);
    chk("idle_stay", 64'({mem_rden, mem_wren}), 64'd0);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, memory address width in bits.
REQ-002 SHALL have parameter DW, default 32, memory data width in bits; DW is a multiple of 8.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have ports a_rden and a_wren, input, 1 bit each, core requester read/write request, level, held until a_done.
REQ-006 SHALL have ports a_addr (AW bits), a_wdata (DW bits) and a_wmask (DW/8 bits), all inputs, core request payload.
REQ-007 SHALL have port a_done, output, 1 bit, one-cycle completion pulse to core.
REQ-008 SHALL have ports b_rden, b_wren, b_addr, b_wdata, b_wmask and b_done, identical in width and meaning to the a_ set, for the secondary (DMA/debug) requester.
REQ-009 SHALL have port rdata, output, DW bits, read data broadcast to both requesters; valid only with the owner's done.
REQ-010 SHALL have ports mem_rden and mem_wren, output, 1 bit each, memory strobes, level.
REQ-011 SHALL have ports mem_addr (AW bits), mem_wdata (DW bits) and mem_wmask (DW/8 bits), all outputs, registered payload.
REQ-012 SHALL have ports mem_done (1 bit) and mem_rdata (DW bits), both inputs, memory completion and read data.

Function
REQ-013 SHALL implement FSM states IDLE, OWN_A and OWN_B.
REQ-014 SHALL, in IDLE with at least one request pending, capture the winner's addr, wdata, wmask and op into registers and move to OWN_A or OWN_B at the next edge.
REQ-015 SHALL assert mem_rden or mem_wren from the captured op in every cycle of OWN_A and OWN_B, and never in IDLE.
REQ-016 SHALL, with request sampled at edge N, assert the memory strobe from cycle N+1 (one cycle grant latency).
REQ-017 SHALL drive the owner's done = mem_done combinationally in OWN_x, and rdata = mem_rdata combinationally.
REQ-018 SHALL hold the non-owner's done at 0 at all times.
REQ-019 SHALL return to IDLE at the edge after mem_done in OWN_x; the next grant is sampled in that IDLE cycle.
REQ-020 SHALL ignore mem_done in IDLE; no done is issued.
REQ-021 SHALL treat a request with both rden and wren high as a write.
REQ-022 SHALL ignore request payload changes after capture until the owner's done.
REQ-023 SHALL, with only one requester pending, grant it regardless of history.
REQ-024 SHALL keep a last_grant bit updated at each grant.

Reset
REQ-025 SHALL, on rst, force state IDLE, mem_rden=0, mem_wren=0, a_done=0, b_done=0, mem_addr/mem_wdata/mem_wmask=0 and last_grant=B.
REQ-026 SHALL, on rst mid-transaction, abandon the transaction with no done issued; the strobe is low in the cycle after the reset edge.

Configuration
REQ-027 SHALL, with macro MEM_ARB_RR_EN defined, resolve simultaneous requests by round-robin: grant the requester that is not last_grant.
REQ-028 SHALL, without MEM_ARB_RR_EN, resolve simultaneous requests by fixed priority: A always wins, and last_grant has no functional effect.

Verification
REQ-029 SHALL cover: A read at addr 0x100; mem_done 3 cycles after strobe with rdata 0xDEADBEEF -> mem_rden high cycles 1-3, a_done pulse at cycle 3, rdata=0xDEADBEEF, b_done=0.
REQ-030 SHALL cover: A and B both request in the same cycle after reset, RR enabled -> A granted first, then B; with A re-requesting -> B granted on the next IDLE.
REQ-031 SHALL cover: the same stimulus with RR disabled and A requesting continuously -> B never granted while A is pending.
REQ-032 SHALL cover: B write addr 0x40, wdata 0x12345678, wmask 0x3, payload changed after grant -> mem_wdata stays 0x12345678, mem_wmask stays 0x3 until b_done.
REQ-033 SHALL cover: rst asserted while in OWN_A with mem_done arriving in the same cycle -> no a_done, state IDLE, strobes 0 in the next cycle.
REQ-034 SHALL cover: mem_done pulsed in IDLE -> a_done=0, b_done=0, no state change.
